// File: rtl/wb_cmd_exec.sv
// wb_cmd_exec: command/response bus to pipelined Wishbone B4 master bridge.
// Optional transaction timeout enabled by defining WB_CMD_EXEC_TIMEOUT_EN.
module wb_cmd_exec #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_stb,
  input  logic [33:0] cmd_word,
  output logic        cmd_busy,
  output logic        rsp_stb,
  output logic [33:0] rsp_word,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [29:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data
);
  localparam logic [1:0] IDLE = 2'd0, STROBE = 2'd1, WAIT = 2'd2;
  logic [1:0]  state;
  logic [29:0] addr;
  logic        inc;
  logic        accept, done, tmo;
  logic [1:0]  op;
  logic [29:0] set_addr;
  always_comb begin
    op       = cmd_word[33:32];
    accept   = cmd_stb && state == IDLE;
    set_addr = cmd_word[31] ? addr + cmd_word[29:0] : cmd_word[29:0];
    done     = state != IDLE && (i_wb_ack || i_wb_err);
  end
`ifdef WB_CMD_EXEC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // cnt counts cycles already spent in STROBE/WAIT before the current one
  always_ff @(posedge clk)
    if (reset || accept) cnt <= '0;
    else if (state != IDLE) cnt <= cnt + CW'(1);
  assign tmo = state != IDLE && !done && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES != 0;
  assign tmo = 1'b0;
`endif
  assign cmd_busy = state != IDLE;
  assign o_wb_sel = 4'hF;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_addr <= '0;
      o_wb_data <= '0;
      addr      <= '0;
      inc       <= 1'b1;
      rsp_stb   <= 1'b0;
      rsp_word  <= '0;
    end else begin
      rsp_stb <= 1'b0;
      if (accept) begin
        if (op == 2'b10) begin
          addr     <= set_addr;
          inc      <= ~cmd_word[30];
          rsp_stb  <= 1'b1;
          rsp_word <= {2'b10, 1'b0, cmd_word[30], set_addr};
        end else if (op == 2'b11) begin
          rsp_stb  <= 1'b1;
          rsp_word <= {2'b11, 32'd2};
        end else begin
          state     <= STROBE;
          o_wb_cyc  <= 1'b1;
          o_wb_stb  <= 1'b1;
          o_wb_we   <= op[0];
          o_wb_addr <= addr;
          if (op[0]) o_wb_data <= cmd_word[31:0];
        end
      end else if (done || tmo) begin
        // err outranks ack; neither present means the timeout fired
        state    <= IDLE;
        o_wb_cyc <= 1'b0;
        o_wb_stb <= 1'b0;
        rsp_stb  <= 1'b1;
        rsp_word <= i_wb_err ? {2'b11, 32'd0} :
                    i_wb_ack ? (o_wb_we ? {2'b01, 32'd0} : {2'b00, i_wb_data}) :
                    {2'b11, 32'd1};
        if (i_wb_ack && !i_wb_err && inc) addr <= addr + 30'd1;
      end else if (state == STROBE && !i_wb_stall) begin
        state    <= WAIT;
        o_wb_stb <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wb_cmd_exec.sv
// tb_wb_cmd_exec: vector table plus scoreboard of expected responses for wb_cmd_exec.
module tb_wb_cmd_exec;
  logic        clk = 1'b0, reset = 1'b1, cmd_stb = 1'b0;
  logic [33:0] cmd_word = '0;
  logic        cmd_busy, rsp_stb, o_wb_cyc, o_wb_stb, o_wb_we;
  logic [33:0] rsp_word;
  logic [29:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_stall = 1'b0, i_wb_ack = 1'b0, i_wb_err = 1'b0;
  logic [31:0] i_wb_data = '0;
  int errors = 0, checks = 0;
  logic [33:0] q[$];

  wb_cmd_exec #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .cmd_stb(cmd_stb), .cmd_word(cmd_word),
    .cmd_busy(cmd_busy), .rsp_stb(rsp_stb), .rsp_word(rsp_word),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [33:0] cmd;
    int          stalls;
    int          mode;   // 0 ack, 1 ack+err, 2 err
    bit          same;   // ack in the cycle stb is accepted
    logic [31:0] rdata;
    logic [29:0] addr;
    logic [33:0] rsp;
  } vec_t;
  vec_t vecs[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!reset && rsp_stb === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got %h expected none", rsp_word);
      end else chk("rsp_word", rsp_word, q.pop_front());
    end

  task automatic drive_resp(input vec_t v);
    i_wb_ack  = v.mode != 2;
    i_wb_err  = v.mode != 0;
    i_wb_data = v.rdata;
  endtask

  task automatic run(input vec_t v);
    @(negedge clk);
    cmd_stb  = 1'b1;
    cmd_word = v.cmd;
    q.push_back(v.rsp);
    @(posedge clk);
    @(negedge clk);
    cmd_stb = 1'b0;
    if (v.cmd[33] == 1'b0) begin
      chk("busy", cmd_busy, 1);
      chk("cyc", o_wb_cyc, 1);
      chk("stb", o_wb_stb, 1);
      chk("we", o_wb_we, v.cmd[32]);
      chk("addr", o_wb_addr, v.addr);
      chk("sel", o_wb_sel, 4'hF);
      if (v.cmd[32]) chk("wdata", o_wb_data, v.cmd[31:0]);
      i_wb_stall = v.stalls > 0;
      for (int i = 0; i < v.stalls; i++) begin
        cmd_stb  = i == 0;
        cmd_word = {2'b11, 32'h0};
        @(posedge clk);
        @(negedge clk);
        cmd_stb = 1'b0;
        chk("stall_stb", o_wb_stb, 1);
        chk("stall_addr", o_wb_addr, v.addr);
        chk("stall_busy", cmd_busy, 1);
      end
      i_wb_stall = 1'b0;
      if (v.same) drive_resp(v);
      @(posedge clk);
      @(negedge clk);
      if (!v.same) begin
        chk("wait_stb", o_wb_stb, 0);
        chk("wait_cyc", o_wb_cyc, 1);
        drive_resp(v);
        @(posedge clk);
        @(negedge clk);
      end
      i_wb_ack = 1'b0;
      i_wb_err = 1'b0;
      chk("done_cyc", o_wb_cyc, 0);
      chk("done_busy", cmd_busy, 0);
    end else begin
      chk("nobus_cyc", o_wb_cyc, 0);
      chk("nobus_busy", cmd_busy, 0);
    end
    chk("rsp_stb", rsp_stb, 1);
    @(negedge clk);
    chk("rsp_pulse", rsp_stb, 0);
    chk("rsp_missing", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{{2'b10, 32'h40000010}, 0, 0, 0, 32'h0,        30'h0,        {2'b10, 32'h40000010}};
    vecs[1]  = '{{2'b00, 32'h0},        0, 0, 0, 32'hA5A5A5A5, 30'h10,       {2'b00, 32'hA5A5A5A5}};
    vecs[2]  = '{{2'b00, 32'h0},        0, 0, 0, 32'h11111111, 30'h10,       {2'b00, 32'h11111111}};
    vecs[3]  = '{{2'b10, 32'h3FFFFFFF}, 0, 0, 0, 32'h0,        30'h0,        {2'b10, 32'h3FFFFFFF}};
    vecs[4]  = '{{2'b01, 32'hDEADBEEF}, 0, 0, 0, 32'h0,        30'h3FFFFFFF, {2'b01, 32'h0}};
    vecs[5]  = '{{2'b00, 32'h0},        4, 0, 0, 32'h12345678, 30'h0,        {2'b00, 32'h12345678}};
    vecs[6]  = '{{2'b00, 32'h0},        0, 0, 1, 32'hCAFEF00D, 30'h1,        {2'b00, 32'hCAFEF00D}};
    vecs[7]  = '{{2'b10, 32'h00000100}, 0, 0, 0, 32'h0,        30'h0,        {2'b10, 32'h00000100}};
    vecs[8]  = '{{2'b10, 32'hBFFFFFFC}, 0, 0, 0, 32'h0,        30'h0,        {2'b10, 32'h000000FC}};
    vecs[9]  = '{{2'b00, 32'h0},        0, 1, 0, 32'h55555555, 30'hFC,       {2'b11, 32'h0}};
    vecs[10] = '{{2'b00, 32'h0},        1, 2, 0, 32'h66666666, 30'hFC,       {2'b11, 32'h0}};
    vecs[11] = '{{2'b00, 32'h0},        0, 0, 0, 32'h00000077, 30'hFC,       {2'b00, 32'h00000077}};
    vecs[12] = '{{2'b11, 32'h0000FFFF}, 0, 0, 0, 32'h0,        30'h0,        {2'b11, 32'd2}};
    vecs[13] = '{{2'b01, 32'h0BADF00D}, 2, 0, 1, 32'h0,        30'hFD,       {2'b01, 32'h0}};
    vecs[14] = '{{2'b10, 32'hC0000003}, 0, 0, 0, 32'h0,        30'h0,        {2'b10, 32'h40000101}};
    vecs[15] = '{{2'b00, 32'h0},        0, 0, 0, 32'h00000005, 30'h101,      {2'b00, 32'h00000005}};
    vecs[16] = '{{2'b00, 32'h0},        0, 0, 1, 32'h00000009, 30'h101,      {2'b00, 32'h00000009}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", cmd_busy, 0);
    chk("rst_rsp_stb", rsp_stb, 0);
    chk("rst_rsp_word", rsp_word, 0);
    chk("rst_cyc", o_wb_cyc, 0);
    chk("rst_stb", o_wb_stb, 0);
    chk("rst_we", o_wb_we, 0);
    chk("rst_data", o_wb_data, 0);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) run(vecs[i]);
    // reset while waiting for ack: no response, address and flag restored
    @(negedge clk);
    cmd_stb  = 1'b1;
    cmd_word = {2'b00, 32'h0};
    @(posedge clk);
    @(negedge clk);
    cmd_stb = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_wait_cyc", o_wb_cyc, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_cyc", o_wb_cyc, 0);
    chk("mid_rst_stb", o_wb_stb, 0);
    chk("mid_rst_rsp", rsp_stb, 0);
    chk("mid_rst_busy", cmd_busy, 0);
    reset = 1'b0;
    run('{{2'b00, 32'h0}, 0, 0, 0, 32'h0000AAAA, 30'h0, {2'b00, 32'h0000AAAA}});
    run('{{2'b00, 32'h0}, 0, 0, 0, 32'h0000BBBB, 30'h1, {2'b00, 32'h0000BBBB}});
`ifdef WB_CMD_EXEC_TIMEOUT_EN
    begin
      int n = 0;
      @(negedge clk);
      cmd_stb  = 1'b1;
      cmd_word = {2'b00, 32'h0};
      q.push_back({2'b11, 32'd1});
      @(posedge clk);
      @(negedge clk);
      cmd_stb = 1'b0;
      while (o_wb_cyc && n < 50) begin
        n++;
        @(posedge clk);
        @(negedge clk);
      end
      chk("tmo_cycles", n, 8);
      chk("tmo_busy", cmd_busy, 0);
      chk("tmo_rsp_stb", rsp_stb, 1);
      @(negedge clk);
      chk("tmo_rsp_missing", q.size(), 0);
      run('{{2'b00, 32'h0}, 0, 0, 0, 32'h0000CCCC, 30'h2, {2'b00, 32'h0000CCCC}});
    end
`endif
    repeat (3) @(negedge clk);
    chk("final_queue", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
